tdp_ram_sc_param: RTL and testbench

- Parametrised single-clock true-dual-port block RAM model; successor to the fixed dual-18Kb split RAM.
- Generalises data/parity width, depth and byte-enable granularity.
- Adds per-port write modes, a selectable output pipeline register, defined cross-port collision rules and a hardware memory-clear sequencer after reset.
- Sits in the BRAM mapping layer as the generic target for inferred RAMs.

---
 rtl/tdp_ram_sc_param_pkg.sv | 14 +
 rtl/tdp_ram_sc_param_if.sv | 37 +++
 rtl/tdp_ram_clear_seq.sv | 48 ++++
 rtl/tdp_ram_sc_param.sv | 116 +++++++++++
 tb/tb_tdp_ram_sc_param.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tdp_ram_sc_param_pkg.sv
// Shared definitions for the parametrised true-dual-port RAM: write-mode codes
// and the clear-sequencer state encoding.
package tdp_ram_sc_param_pkg;

   localparam int WM_WRITE_FIRST = 0;
   localparam int WM_READ_FIRST  = 1;
   localparam int WM_NO_CHANGE   = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clear_state_t;

endpackage

// File: rtl/tdp_ram_sc_param_if.sv
// Port bundle for both RAM ports plus BUSY.
// A request is taken on a CLK edge where WEN_x/REN_x is high and BUSY is low;
// there is no other back-pressure, and requests made while BUSY is high are dropped.
interface tdp_ram_sc_param_if #(
   parameter int DATA_WIDTH = 18,
   parameter int BYTE_WIDTH = 9,
   parameter int ADDR_WIDTH = 10
);
   localparam int NB = DATA_WIDTH / BYTE_WIDTH;

   logic                  WEN_A;
   logic                  REN_A;
   logic [NB-1:0]         BE_A;
   logic [ADDR_WIDTH-1:0] ADDR_A;
   logic [DATA_WIDTH-1:0] WDATA_A;
   logic [DATA_WIDTH-1:0] RDATA_A;
   logic                  WEN_B;
   logic                  REN_B;
   logic [NB-1:0]         BE_B;
   logic [ADDR_WIDTH-1:0] ADDR_B;
   logic [DATA_WIDTH-1:0] WDATA_B;
   logic [DATA_WIDTH-1:0] RDATA_B;
   logic                  BUSY;

   modport master (
      output WEN_A, REN_A, BE_A, ADDR_A, WDATA_A,
      output WEN_B, REN_B, BE_B, ADDR_B, WDATA_B,
      input  RDATA_A, RDATA_B, BUSY
   );

   modport slave (
      input  WEN_A, REN_A, BE_A, ADDR_A, WDATA_A,
      input  WEN_B, REN_B, BE_B, ADDR_B, WDATA_B,
      output RDATA_A, RDATA_B, BUSY
   );

endinterface

// File: rtl/tdp_ram_clear_seq.sv
// Post-reset memory-clear sequencer: walks every address once, writing zero,
// and holds BUSY while doing so.
module tdp_ram_clear_seq
   import tdp_ram_sc_param_pkg::*;
#(
   parameter int ADDR_WIDTH     = 10,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  busy,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr,
   output clear_state_t          state_dbg
);

   clear_state_t          state;
   clear_state_t          state_nxt;
   logic [ADDR_WIDTH-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_CLEAR) cnt <= cnt + 1'b1;
      end
   end

   // The last address is written on the same edge that returns to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_CLEAR: if (cnt == '1) state_nxt = ST_IDLE;
         ST_IDLE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == ST_CLEAR);
      clr_we    = (state == ST_CLEAR) && !rst;
      clr_addr  = cnt;
      state_dbg = state;
   end

endmodule

// File: rtl/tdp_ram_sc_param.sv
// Single-clock true-dual-port RAM with byte-lane enables, per-port write modes,
// optional output register and a hardware clear after reset.
module tdp_ram_sc_param
   import tdp_ram_sc_param_pkg::*;
#(
   parameter int DATA_WIDTH     = 18,
   parameter int BYTE_WIDTH     = 9,
   parameter int ADDR_WIDTH     = 10,
   parameter int READ_LATENCY   = 1,
   parameter int WRITE_MODE_A   = 0,
   parameter int WRITE_MODE_B   = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic               CLK,
   input  logic               RESET,
   tdp_ram_sc_param_if.slave  bus,
   output clear_state_t       dbg_state
);

   localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   if ((DATA_WIDTH % BYTE_WIDTH) != 0 || (BYTE_WIDTH != 8 && BYTE_WIDTH != 9) ||
       (READ_LATENCY != 1 && READ_LATENCY != 2) ||
       WRITE_MODE_A < 0 || WRITE_MODE_A > WM_NO_CHANGE ||
       WRITE_MODE_B < 0 || WRITE_MODE_B > WM_NO_CHANGE) begin : g_bad_cfg
      $fatal(1, "tdp_ram_sc_param: invalid parameter combination");
   end

   function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_w,
                                                         input logic [DATA_WIDTH-1:0] new_w,
                                                         input logic [NB-1:0]         be);
      merge_lanes = old_w;
      for (int i = 0; i < NB; i++)
         if (be[i]) merge_lanes[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
   endfunction

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  busy, clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  port_ok, wr_a, rd_a, wr_b, rd_b;
   logic [DATA_WIDTH-1:0] old_a, old_b, val_a, val_b;
   logic                  ld_a, ld_b, v_a, v_b;
   logic [DATA_WIDTH-1:0] s1_a, s1_b, s2_a, s2_b;

   tdp_ram_clear_seq #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear (
      .clk       (CLK),
      .rst       (RESET),
      .busy      (busy),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr),
      .state_dbg (dbg_state)
   );

   assign port_ok = !busy && !RESET;
   assign wr_a    = bus.WEN_A && port_ok;
   assign rd_a    = bus.REN_A && port_ok;
   assign wr_b    = bus.WEN_B && port_ok;
   assign rd_b    = bus.REN_B && port_ok;
   assign old_a   = mem[bus.ADDR_A];
   assign old_b   = mem[bus.ADDR_B];

   // A reader always sees the pre-edge word unless its own port writes in WRITE_FIRST mode.
   always_comb begin
      val_a = old_a;
      ld_a  = 1'b0;
      if (rd_a) begin
         if (wr_a && WRITE_MODE_A == WM_WRITE_FIRST) val_a = merge_lanes(old_a, bus.WDATA_A, bus.BE_A);
         ld_a = !(wr_a && WRITE_MODE_A == WM_NO_CHANGE);
      end
      val_b = old_b;
      ld_b  = 1'b0;
      if (rd_b) begin
         if (wr_b && WRITE_MODE_B == WM_WRITE_FIRST) val_b = merge_lanes(old_b, bus.WDATA_B, bus.BE_B);
         ld_b = !(wr_b && WRITE_MODE_B == WM_NO_CHANGE);
      end
   end

   // Port B lanes are assigned first so port A overrides it on shared lanes.
   always_ff @(posedge CLK) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (wr_b && bus.BE_B[i]) mem[bus.ADDR_B][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.WDATA_B[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr_a && bus.BE_A[i]) mem[bus.ADDR_A][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.WDATA_A[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         s1_a <= '0;
         s1_b <= '0;
         s2_a <= '0;
         s2_b <= '0;
         v_a  <= 1'b0;
         v_b  <= 1'b0;
      end else begin
         if (ld_a) s1_a <= val_a;
         if (ld_b) s1_b <= val_b;
         v_a <= ld_a;
         v_b <= ld_b;
         if (v_a) s2_a <= s1_a;
         if (v_b) s2_b <= s1_b;
      end
   end

   assign bus.RDATA_A = (READ_LATENCY == 2) ? s2_a : s1_a;
   assign bus.RDATA_B = (READ_LATENCY == 2) ? s2_b : s1_b;
   assign bus.BUSY    = busy;

endmodule

// File: tb/tb_tdp_ram_sc_param.sv
// Bench for tdp_ram_sc_param: three instances (WRITE_FIRST/lat1, READ_FIRST/lat2,
// NO_CHANGE/lat1) share one stimulus stream and are checked against a word-level model.
module tb_tdp_ram_sc_param;
   import tdp_ram_sc_param_pkg::*;

   localparam int DW    = 18;
   localparam int BW    = 9;
   localparam int AW    = 10;
   localparam int NB    = DW / BW;
   localparam int DEPTH = 1 << AW;
   localparam int NI    = 3;
   localparam int LAT [NI] = '{1, 2, 1};
   localparam int WM  [NI] = '{WM_WRITE_FIRST, WM_READ_FIRST, WM_NO_CHANGE};

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          wen_a, ren_a, wen_b, ren_b;
   logic [NB-1:0] be_a, be_b;
   logic [AW-1:0] addr_a, addr_b;
   logic [DW-1:0] wd_a, wd_b;
   logic [DW-1:0] rd_a [NI];
   logic [DW-1:0] rd_b [NI];
   logic          busy [NI];
   clear_state_t  dbg  [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      tdp_ram_sc_param_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus_if ();
      assign bus_if.WEN_A   = wen_a;
      assign bus_if.REN_A   = ren_a;
      assign bus_if.BE_A    = be_a;
      assign bus_if.ADDR_A  = addr_a;
      assign bus_if.WDATA_A = wd_a;
      assign bus_if.WEN_B   = wen_b;
      assign bus_if.REN_B   = ren_b;
      assign bus_if.BE_B    = be_b;
      assign bus_if.ADDR_B  = addr_b;
      assign bus_if.WDATA_B = wd_b;
      assign rd_a[g]        = bus_if.RDATA_A;
      assign rd_b[g]        = bus_if.RDATA_B;
      assign busy[g]        = bus_if.BUSY;
      tdp_ram_sc_param #(
         .DATA_WIDTH     (DW),
         .BYTE_WIDTH     (BW),
         .ADDR_WIDTH     (AW),
         .READ_LATENCY   (LAT[g]),
         .WRITE_MODE_A   (WM[g]),
         .WRITE_MODE_B   (WM[g]),
         .CLEAR_ON_RESET (1)
      ) u_dut (
         .CLK       (clk),
         .RESET     (rst),
         .bus       (bus_if),
         .dbg_state (dbg[g])
      );
   end

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                                input logic [NB-1:0] be);
      logic [DW-1:0] mask;
      mask = '0;
      for (int i = 0; i < NB; i++)
         if (be[i]) mask = mask | (DW'((1 << BW) - 1) << (i * BW));
      return (old_w & ~mask) | (new_w & mask);
   endfunction

   // ---------------- reference model ----------------
   logic [DW-1:0] m_mem [DEPTH];
   int            busy_rem = 0;
   logic [DW-1:0] ea [NI];
   logic [DW-1:0] eb [NI];
   logic [DW-1:0] sa [NI];
   logic [DW-1:0] sb [NI];
   logic          va [NI];
   logic          vb [NI];

   always @(posedge clk) begin : model
      logic [DW-1:0] old_a, old_b, val;
      logic          ok, fire;
      if (rst) begin
         busy_rem = DEPTH;
         for (int g = 0; g < NI; g++) begin
            ea[g] = '0; eb[g] = '0; sa[g] = '0; sb[g] = '0; va[g] = 1'b0; vb[g] = 1'b0;
         end
      end else begin
         ok    = (busy_rem == 0);
         old_a = m_mem[addr_a];
         old_b = m_mem[addr_b];
         for (int g = 0; g < NI; g++) begin
            fire = ok && ren_a && !(wen_a && WM[g] == WM_NO_CHANGE);
            val  = (wen_a && WM[g] == WM_WRITE_FIRST) ? lane_merge(old_a, wd_a, be_a) : old_a;
            if (LAT[g] == 1) begin
               if (fire) ea[g] = val;
            end else begin
               if (va[g]) ea[g] = sa[g];
               if (fire) sa[g] = val;
               va[g] = fire;
            end
            fire = ok && ren_b && !(wen_b && WM[g] == WM_NO_CHANGE);
            val  = (wen_b && WM[g] == WM_WRITE_FIRST) ? lane_merge(old_b, wd_b, be_b) : old_b;
            if (LAT[g] == 1) begin
               if (fire) eb[g] = val;
            end else begin
               if (vb[g]) eb[g] = sb[g];
               if (fire) sb[g] = val;
               vb[g] = fire;
            end
         end
         if (!ok) begin
            m_mem[DEPTH - busy_rem] = '0;
            busy_rem--;
         end else begin
            if (wen_b) m_mem[addr_b] = lane_merge(m_mem[addr_b], wd_b, be_b);
            if (wen_a) m_mem[addr_a] = lane_merge(m_mem[addr_a], wd_a, be_a);
         end
      end
      #1;
      for (int g = 0; g < NI; g++) begin
         check($sformatf("model_rdata_a[%0d]", g), 32'(rd_a[g]), 32'(ea[g]));
         check($sformatf("model_rdata_b[%0d]", g), 32'(rd_b[g]), 32'(eb[g]));
         check($sformatf("model_busy[%0d]", g), 32'(busy[g]), 32'(busy_rem != 0));
         check($sformatf("model_state[%0d]", g), 32'(dbg[g]), 32'((busy_rem != 0) ? ST_CLEAR : ST_IDLE));
      end
   end

   // ---------------- directed vectors ----------------
   typedef struct {
      logic          wen_a, ren_a;
      logic [NB-1:0] be_a;
      logic [AW-1:0] addr_a;
      logic [DW-1:0] wd_a;
      logic          wen_b, ren_b;
      logic [NB-1:0] be_b;
      logic [AW-1:0] addr_b;
      logic [DW-1:0] wd_b;
      logic [NI-1:0] chk_a, chk_b;
      logic [DW-1:0] ea [NI];
      logic [DW-1:0] eb [NI];
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic wa, input logic ra, input logic [NB-1:0] ba, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                          input logic wb, input logic rb, input logic [NB-1:0] bb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                          input logic [NI-1:0] ca, input logic [NI-1:0] cb,
                          input logic [DW-1:0] a0, input logic [DW-1:0] a1, input logic [DW-1:0] a2,
                          input logic [DW-1:0] b0, input logic [DW-1:0] b1, input logic [DW-1:0] b2);
      vec_t v;
      v.wen_a = wa; v.ren_a = ra; v.be_a = ba; v.addr_a = aa; v.wd_a = da;
      v.wen_b = wb; v.ren_b = rb; v.be_b = bb; v.addr_b = ab; v.wd_b = db;
      v.chk_a = ca; v.chk_b = cb;
      v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2;
      v.eb[0] = b0; v.eb[1] = b1; v.eb[2] = b2;
      vecs.push_back(v);
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      wen_a = 0; ren_a = 0; be_a = '0; addr_a = '0; wd_a = '0;
      wen_b = 0; ren_b = 0; be_b = '0; addr_b = '0; wd_b = '0;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return AW'(10'h3F8 + $urandom_range(0, 7));
      return AW'($urandom_range(0, 7));
   endfunction

   task automatic rand_inputs();
      wen_a = 1'($urandom_range(0, 1)); ren_a = 1'($urandom_range(0, 1));
      be_a = NB'($urandom_range(0, 3)); addr_a = rand_addr(); wd_a = DW'($urandom);
      wen_b = 1'($urandom_range(0, 1)); ren_b = 1'($urandom_range(0, 1));
      be_b = NB'($urandom_range(0, 3)); addr_b = rand_addr(); wd_b = DW'($urandom);
   endtask

   task automatic count_busy(output int cnt);
      cnt = 0;
      while (busy[0] && cnt < 4000) begin
         @(negedge clk);
         rand_inputs();
         cnt++;
      end
      set_idle();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int cnt;
      set_idle();
      //      wa ra ba    aa      da       | wb rb bb    ab      db       | ca      cb      | a0..a2                          | b0..b2
      add_vec(1, 0, 2'b11, 10'd5,  18'h2ABCD, 0, 0, 2'b00, 10'd0, 18'h0,     3'b000, 3'b000, 18'h0,     18'h0,     18'h0,     18'h0,     18'h0,     18'h0);
      add_vec(0, 0, 2'b00, 10'd0,  18'h0,     0, 1, 2'b00, 10'd5, 18'h0,     3'b000, 3'b101, 18'h0,     18'h0,     18'h0,     18'h2ABCD, 18'h0,     18'h2ABCD);
      add_vec(0, 0, 2'b00, 10'd0,  18'h0,     0, 0, 2'b00, 10'd0, 18'h0,     3'b000, 3'b111, 18'h0,     18'h0,     18'h0,     18'h2ABCD, 18'h2ABCD, 18'h2ABCD);
      add_vec(1, 0, 2'b11, 10'd7,  18'h11111, 0, 0, 2'b00, 10'd0, 18'h0,     3'b000, 3'b000, 18'h0,     18'h0,     18'h0,     18'h0,     18'h0,     18'h0);
      add_vec(1, 1, 2'b01, 10'd7,  18'h3FFFF, 0, 0, 2'b00, 10'd0, 18'h0,     3'b101, 3'b000, 18'h111FF, 18'h0,     18'h0,     18'h0,     18'h0,     18'h0);
      add_vec(0, 0, 2'b00, 10'd0,  18'h0,     0, 0, 2'b00, 10'd0, 18'h0,     3'b111, 3'b000, 18'h111FF, 18'h11111, 18'h0,     18'h0,     18'h0,     18'h0);
      add_vec(1, 0, 2'b11, 10'd9,  18'h00001, 1, 0, 2'b11, 10'd9, 18'h3FE00, 3'b000, 3'b000, 18'h0,     18'h0,     18'h0,     18'h0,     18'h0,     18'h0);
      add_vec(0, 1, 2'b00, 10'd9,  18'h0,     0, 0, 2'b00, 10'd0, 18'h0,     3'b101, 3'b000, 18'h00001, 18'h0,     18'h00001, 18'h0,     18'h0,     18'h0);
      add_vec(0, 0, 2'b00, 10'd0,  18'h0,     0, 1, 2'b00, 10'd7, 18'h0,     3'b010, 3'b101, 18'h0,     18'h00001, 18'h0,     18'h111FF, 18'h0,     18'h111FF);
      add_vec(1, 0, 2'b01, 10'd9,  18'h00001, 1, 0, 2'b10, 10'd9, 18'h3FE00, 3'b000, 3'b010, 18'h0,     18'h0,     18'h0,     18'h0,     18'h111FF, 18'h0);
      add_vec(0, 0, 2'b00, 10'd0,  18'h0,     0, 1, 2'b00, 10'd9, 18'h0,     3'b000, 3'b101, 18'h0,     18'h0,     18'h0,     18'h3FE01, 18'h0,     18'h3FE01);
      add_vec(1, 0, 2'b11, 10'd3,  18'h15555, 0, 1, 2'b00, 10'd3, 18'h0,     3'b000, 3'b111, 18'h0,     18'h0,     18'h0,     18'h0,     18'h3FE01, 18'h0);
      add_vec(0, 0, 2'b00, 10'd0,  18'h0,     0, 1, 2'b00, 10'd3, 18'h0,     3'b000, 3'b111, 18'h0,     18'h0,     18'h0,     18'h15555, 18'h0,     18'h15555);
      add_vec(0, 0, 2'b00, 10'd0,  18'h0,     0, 0, 2'b00, 10'd0, 18'h0,     3'b000, 3'b010, 18'h0,     18'h0,     18'h0,     18'h0,     18'h15555, 18'h0);
      add_vec(0, 1, 2'b00, 10'h3FF, 18'h0,    1, 1, 2'b10, 10'd3, 18'h2AAAA, 3'b101, 3'b101, 18'h0,     18'h0,     18'h0,     18'h2AB55, 18'h0,     18'h15555);
      add_vec(0, 0, 2'b00, 10'd0,  18'h0,     0, 0, 2'b00, 10'd0, 18'h0,     3'b010, 3'b010, 18'h0,     18'h0,     18'h0,     18'h0,     18'h15555, 18'h0);
      add_vec(1, 0, 2'b00, 10'd5,  18'h0,     0, 0, 2'b00, 10'd0, 18'h0,     3'b000, 3'b000, 18'h0,     18'h0,     18'h0,     18'h0,     18'h0,     18'h0);
      add_vec(0, 1, 2'b00, 10'd5,  18'h0,     0, 0, 2'b00, 10'd0, 18'h0,     3'b101, 3'b000, 18'h2ABCD, 18'h0,     18'h2ABCD, 18'h0,     18'h0,     18'h0);
      add_vec(0, 0, 2'b00, 10'd0,  18'h0,     0, 0, 2'b00, 10'd0, 18'h0,     3'b010, 3'b000, 18'h0,     18'h2ABCD, 18'h0,     18'h0,     18'h0,     18'h0);

      // Reset state, then the initial clear length.
      repeat (3) @(negedge clk);
      for (int g = 0; g < NI; g++) begin
         check($sformatf("reset_rdata_a[%0d]", g), 32'(rd_a[g]), 32'h0);
         check($sformatf("reset_rdata_b[%0d]", g), 32'(rd_b[g]), 32'h0);
         check($sformatf("reset_busy[%0d]", g), 32'(busy[g]), 32'h1);
      end
      rst = 1'b0;
      count_busy(cnt);
      check("initial_clear_cycles", 32'(cnt), 32'd1024);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         wen_a = vecs[i].wen_a; ren_a = vecs[i].ren_a; be_a = vecs[i].be_a; addr_a = vecs[i].addr_a; wd_a = vecs[i].wd_a;
         wen_b = vecs[i].wen_b; ren_b = vecs[i].ren_b; be_b = vecs[i].be_b; addr_b = vecs[i].addr_b; wd_b = vecs[i].wd_b;
         @(posedge clk);
         #1;
         for (int g = 0; g < NI; g++) begin
            if (vecs[i].chk_a[g]) check($sformatf("vec%0d_rdata_a[%0d]", i, g), 32'(rd_a[g]), 32'(vecs[i].ea[g]));
            if (vecs[i].chk_b[g]) check($sformatf("vec%0d_rdata_b[%0d]", i, g), 32'(rd_b[g]), 32'(vecs[i].eb[g]));
         end
      end
      @(negedge clk);
      set_idle();

      // Randomized traffic concentrated on a few addresses to provoke collisions.
      repeat (2000) begin
         @(negedge clk);
         rand_inputs();
      end

      // Plant known non-zero words so the second clear is observable.
      @(negedge clk);
      set_idle();
      wen_a = 1; be_a = 2'b11; addr_a = 10'd5; wd_a = 18'h3FFFF;
      wen_b = 1; be_b = 2'b11; addr_b = 10'h3FF; wd_b = 18'h12345;
      @(negedge clk);
      set_idle();
      ren_a = 1; addr_a = 10'd5; ren_b = 1; addr_b = 10'h3FF;
      @(posedge clk);
      #1;
      check("preclear_read_a", 32'(rd_a[0]), 32'h3FFFF);
      check("preclear_read_b", 32'(rd_b[0]), 32'h12345);

      // Reset pulsed part-way through a clear restarts the full sweep.
      @(negedge clk);
      set_idle();
      rst = 1'b1;
      @(negedge clk);
      for (int g = 0; g < NI; g++) check($sformatf("rereset_rdata_a[%0d]", g), 32'(rd_a[g]), 32'h0);
      rst = 1'b0;
      repeat (500) begin
         @(negedge clk);
         rand_inputs();
      end
      check("midclear_busy", 32'(busy[0]), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      check("midclear_busy_in_reset", 32'(busy[0]), 32'h1);
      rst = 1'b0;
      count_busy(cnt);
      check("restarted_clear_cycles", 32'(cnt), 32'd1024);

      @(negedge clk);
      ren_a = 1; addr_a = 10'd5; ren_b = 1; addr_b = 10'h3FF;
      @(posedge clk);
      #1;
      check("postclear_read_a_addr5", 32'(rd_a[0]), 32'h0);
      check("postclear_read_b_addr3ff", 32'(rd_b[0]), 32'h0);
      @(negedge clk);
      set_idle();
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
